// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences fetch, register
// file, ALU and data memory, and counts retired instructions.
module mc_ctrl #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             npc_sel,
  output logic             j,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             done,
  output logic [2:0]       state,
  output logic [RET_W-1:0] ret_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opQ;
  logic [5:0]       r_fnQ;
  logic [RET_W-1:0] r_retCnt;

  logic w_isR, w_isAddu, w_isSubu, w_isOri, w_isLui;
  logic w_isLw, w_isSw, w_isBeq, w_isJ, w_legal;

  logic       w_pcWe, w_npcSel, w_j, w_regWe, w_regDst, w_aluSrc;
  logic [1:0] w_extOp, w_aluOp;
  logic       w_memRe, w_memWe, w_memToReg, w_illegal, w_done;

  // Decode works only on the captured fields; the fetch unit's fields move once PC advances.
  assign w_isR    = (r_opQ == 6'b000000);
  assign w_isAddu = w_isR && (r_fnQ == 6'b100001);
  assign w_isSubu = w_isR && (r_fnQ == 6'b100011);
  assign w_isOri  = (r_opQ == 6'b001101);
  assign w_isLui  = (r_opQ == 6'b001111);
  assign w_isLw   = (r_opQ == 6'b100011);
  assign w_isSw   = (r_opQ == 6'b101011);
  assign w_isBeq  = (r_opQ == 6'b000100);
  assign w_isJ    = (r_opQ == 6'b000010);
  assign w_legal  = w_isAddu | w_isSubu | w_isOri | w_isLui |
                    w_isLw | w_isSw | w_isBeq | w_isJ;

  always_comb begin
    w_next     = S_IF;
    w_pcWe     = 1'b0;
    w_npcSel   = 1'b0;
    w_j        = 1'b0;
    w_regWe    = 1'b0;
    w_regDst   = 1'b0;
    w_aluSrc   = 1'b0;
    w_extOp    = EXT_ZERO;
    w_aluOp    = ALU_ADD;
    w_memRe    = 1'b0;
    w_memWe    = 1'b0;
    w_memToReg = 1'b0;
    w_illegal  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IF: begin
        w_pcWe = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        if (w_isJ) begin
          w_pcWe = 1'b1;
          w_j    = 1'b1;
          w_done = 1'b1;
        end else if (!w_legal) begin
          w_illegal = 1'b1;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_isAddu || w_isSubu) begin
          w_aluOp = w_isSubu ? ALU_SUB : ALU_ADD;
          w_next  = S_WB;
        end else if (w_isOri || w_isLui) begin
          w_aluSrc = 1'b1;
          w_extOp  = w_isLui ? EXT_LUI : EXT_ZERO;
          w_aluOp  = ALU_OR;
          w_next   = S_WB;
        end else if (w_isLw || w_isSw) begin
          w_aluSrc = 1'b1;
          w_extOp  = EXT_SIGN;
          w_next   = S_MEM;
        end else if (w_isBeq) begin
          w_aluOp  = ALU_SUB;
          w_npcSel = 1'b1;
          w_pcWe   = zero;
          w_done   = 1'b1;
        end
      end
      // The address stays driven for the whole memory wait.
      S_MEM: begin
        w_aluSrc = 1'b1;
        w_extOp  = EXT_SIGN;
        if (w_isLw) begin
          w_memRe = 1'b1;
          w_next  = mem_ready ? S_WB : S_MEM;
        end else if (w_isSw) begin
          w_memWe = 1'b1;
          w_done  = mem_ready;
          w_next  = mem_ready ? S_IF : S_MEM;
        end
      end
      S_WB: begin
        w_regWe = 1'b1;
        w_done  = 1'b1;
        if (w_isLw) begin
          w_memToReg = 1'b1;
        end else if (w_isAddu || w_isSubu) begin
          w_regDst = 1'b1;
          w_aluOp  = w_isSubu ? ALU_SUB : ALU_ADD;
        end else if (w_isOri || w_isLui) begin
          w_aluSrc = 1'b1;
          w_extOp  = w_isLui ? EXT_LUI : EXT_ZERO;
          w_aluOp  = ALU_OR;
        end
      end
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IF;
      r_opQ    <= 6'd0;
      r_fnQ    <= 6'd0;
      r_retCnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) begin
        r_opQ <= opcode;
        r_fnQ <= funct;
      end
      if (w_done) begin
        r_retCnt <= r_retCnt + {{(RET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Reset silences every output so nothing downstream acts on a half-run instruction.
  assign pc_we      = w_pcWe     & ~reset;
  assign npc_sel    = w_npcSel   & ~reset;
  assign j          = w_j        & ~reset;
  assign reg_we     = w_regWe    & ~reset;
  assign reg_dst    = w_regDst   & ~reset;
  assign alu_src    = w_aluSrc   & ~reset;
  assign ext_op     = reset ? 2'd0 : w_extOp;
  assign alu_op     = reset ? 2'd0 : w_aluOp;
  assign mem_re     = w_memRe    & ~reset;
  assign mem_we     = w_memWe    & ~reset;
  assign mem_to_reg = w_memToReg & ~reset;
  assign illegal    = w_illegal  & ~reset;
  assign done       = w_done     & ~reset;
  assign state      = reset ? 3'd0 : r_state;
  assign ret_cnt    = reset ? '0 : r_retCnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by cycle
// against hand-computed output vectors.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_we, npc_sel, j, reg_we, reg_dst, alu_src;
  logic [1:0]  ext_op, alu_op;
  logic        mem_re, mem_we, mem_to_reg, illegal, done;
  logic [2:0]  state;
  logic [31:0] ret_cnt;

  int nVectors = 0;
  int nMiscompares = 0;

  // Packed view: state | pc_we npc_sel j | reg_we reg_dst alu_src | ext_op | alu_op | mem_re mem_we mem_to_reg | illegal done
  logic [17:0] obs;
  assign obs = {state, pc_we, npc_sel, j, reg_we, reg_dst, alu_src, ext_op, alu_op,
                mem_re, mem_we, mem_to_reg, illegal, done};

  localparam logic [17:0] EXP_IF = 18'b000_100_000_00_00_000_00;
  localparam logic [17:0] EXP_ID = 18'b001_000_000_00_00_000_00;

  mc_ctrl #(.RET_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .npc_sel(npc_sel), .j(j),
    .reg_we(reg_we), .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .done(done), .state(state), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      nVectors++;
      if (obs !== 18'd0 || ret_cnt !== 32'd0) begin
        nMiscompares++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b/%0d, expected %b/0", c, obs, ret_cnt, 18'd0);
      end
      @(posedge clk);
    end
    #1 reset = 1'b0;
    #1;
    nVectors++;
    if (obs !== EXP_IF || ret_cnt !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_release: got %b/%0d, expected %b/0", obs, ret_cnt, EXP_IF);
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [1:0] aop, input int expRet);
    logic [17:0] exp[4];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = {3'd2, 3'b000, 3'b000, 2'd0, aop, 3'b000, 2'b00};
    exp[3] = {3'd4, 3'b000, 3'b110, 2'd0, aop, 3'b000, 2'b01};
    for (int c = 0; c < 4; c++) begin
      opcode = (c == 0) ? 6'h00 : 6'h3F;
      funct  = (c == 0) ? fn : 6'h3F;
      zero = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL rtype fn=%h cycle %0d: got %b, expected %b", fn, c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL rtype_end fn=%h: got state %0d ret %0d, expected 0 / %0d", fn, state, ret_cnt, expRet);
    end
  endtask

  task automatic test_imm(input logic [5:0] op, input logic [1:0] ext, input int expRet);
    logic [17:0] exp[4];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = {3'd2, 3'b000, 3'b001, ext, 2'd2, 3'b000, 2'b00};
    exp[3] = {3'd4, 3'b000, 3'b101, ext, 2'd2, 3'b000, 2'b01};
    for (int c = 0; c < 4; c++) begin
      opcode = (c == 0) ? op : 6'h3F;
      funct  = 6'h21;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL imm op=%h cycle %0d: got %b, expected %b", op, c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL imm_end op=%h: got state %0d ret %0d, expected 0 / %0d", op, state, ret_cnt, expRet);
    end
  endtask

  task automatic test_lw_wait(input int expRet);
    logic [17:0] exp[7];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = 18'b010_000_001_01_00_000_00;
    exp[3] = 18'b011_000_001_01_00_100_00;
    exp[4] = 18'b011_000_001_01_00_100_00;
    exp[5] = 18'b011_000_001_01_00_100_00;
    exp[6] = 18'b100_000_100_00_00_001_01;
    for (int c = 0; c < 7; c++) begin
      opcode = (c == 0) ? 6'h23 : 6'h3F;
      mem_ready = (c < 2) || (c == 5);
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL lw_wait cycle %0d: got %b, expected %b", c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL lw_end: got state %0d ret %0d, expected 0 / %0d", state, ret_cnt, expRet);
    end
  endtask

  task automatic test_sw(input int expRet);
    logic [17:0] exp[4];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = 18'b010_000_001_01_00_000_00;
    exp[3] = 18'b011_000_001_01_00_010_01;
    for (int c = 0; c < 4; c++) begin
      opcode = (c == 0) ? 6'h2B : 6'h3F;
      mem_ready = 1'b1;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL sw cycle %0d: got %b, expected %b", c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL sw_end: got state %0d ret %0d, expected 0 / %0d", state, ret_cnt, expRet);
    end
  endtask

  task automatic test_beq(input logic z, input int expRet);
    logic [17:0] exp[3];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = {3'd2, z, 2'b10, 3'b000, 2'd0, 2'd1, 3'b000, 2'b01};
    for (int c = 0; c < 3; c++) begin
      opcode = (c == 0) ? 6'h04 : 6'h3F;
      zero = (c == 2) ? z : ~z;
      mem_ready = 1'b1;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL beq zero=%0d cycle %0d: got %b, expected %b", z, c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL beq_end zero=%0d: got state %0d ret %0d, expected 0 / %0d", z, state, ret_cnt, expRet);
    end
  endtask

  task automatic test_jump(input int expRet);
    logic [17:0] exp[2];
    exp[0] = EXP_IF;
    exp[1] = 18'b001_101_000_00_00_000_01;
    for (int c = 0; c < 2; c++) begin
      opcode = (c == 0) ? 6'h02 : 6'h3F;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL jump cycle %0d: got %b, expected %b", c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL jump_end: got state %0d ret %0d, expected 0 / %0d", state, ret_cnt, expRet);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn, input int expRet);
    logic [17:0] exp[2];
    exp[0] = EXP_IF;
    exp[1] = 18'b001_000_000_00_00_000_10;
    for (int c = 0; c < 2; c++) begin
      opcode = (c == 0) ? op : 6'h02;
      funct  = (c == 0) ? fn : 6'h21;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL illegal op=%h fn=%h cycle %0d: got %b, expected %b", op, fn, c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (state !== 3'd0 || ret_cnt !== expRet) begin
      nMiscompares++;
      $display("[TB] FAIL illegal_end op=%h: got state %0d ret %0d, expected 0 / %0d", op, state, ret_cnt, expRet);
    end
  endtask

  task automatic test_reset_in_mem(input int expRetBefore);
    logic [17:0] exp[4];
    exp[0] = EXP_IF;
    exp[1] = EXP_ID;
    exp[2] = 18'b010_000_001_01_00_000_00;
    exp[3] = 18'b011_000_001_01_00_010_00;
    for (int c = 0; c < 4; c++) begin
      opcode = (c == 0) ? 6'h2B : 6'h3F;
      mem_ready = 1'b0;
      @(negedge clk);
      nVectors++;
      if (obs !== exp[c]) begin
        nMiscompares++;
        $display("[TB] FAIL sw_wait cycle %0d: got %b, expected %b", c, obs, exp[c]);
      end
      @(posedge clk);
      #1;
    end
    nVectors++;
    if (ret_cnt !== expRetBefore) begin
      nMiscompares++;
      $display("[TB] FAIL sw_wait_ret: got %0d, expected %0d", ret_cnt, expRetBefore);
    end
    reset = 1'b1;
    @(negedge clk);
    nVectors++;
    if (obs !== 18'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_in_mem: got %b, expected %b", obs, 18'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    nVectors++;
    if (obs !== EXP_IF || ret_cnt !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL post_reset_if: got %b/%0d, expected %b/0", obs, ret_cnt, EXP_IF);
    end
    opcode = 6'h00;
    funct  = 6'h21;
    @(negedge clk);
    @(posedge clk);
    #1;
    nVectors++;
    if (state !== 3'd1 || ret_cnt !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL post_reset_id: got state %0d ret %0d, expected 1 / 0", state, ret_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rtype(6'h21, 2'd0, 1);
    test_rtype(6'h23, 2'd1, 2);
    test_imm(6'h0D, 2'd0, 3);
    test_imm(6'h0F, 2'd2, 4);
    test_lw_wait(5);
    test_sw(6);
    test_beq(1'b1, 7);
    test_beq(1'b0, 8);
    test_jump(9);
    test_illegal(6'h3F, 6'h21, 9);
    test_illegal(6'h00, 6'h20, 9);
    test_reset_in_mem(9);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
